// File: rtl/freq_stepper.sv
// Frequency stepper: applies optimiser step strobes to a clamped drive frequency,
// derives the half-period with a serial divider and drives a dead-timed half-bridge.
module freq_stepper #(
  parameter int CLK_HZ = 50000000,
  parameter int F_INIT = 40000,
  parameter int F_MIN  = 20000,
  parameter int F_MAX  = 100000,
  parameter int F_STEP = 100,
  parameter int DEAD   = 10,
  parameter int HP_W   = 16
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            freq_ready,
  input  logic            freq_set_up_down,
  input  logic            freq_opt,
  output logic [19:0]     freq,
  output logic [HP_W-1:0] half_period,
  output logic            pwm_h,
  output logic            pwm_l,
  output logic            data_start,
  output logic            busy,
  output logic            at_limit
);

  localparam int DVD_W = 25;
  localparam logic [DVD_W-1:0]  DVD     = DVD_W'(CLK_HZ / 2);
  localparam logic [HP_W-1:0]   HP_INIT = HP_W'(CLK_HZ / (2 * F_INIT));
  localparam logic [HP_W-1:0]   DEAD_C  = HP_W'(DEAD);
  localparam logic signed [20:0] STEP_S = 21'(F_STEP);
  localparam logic signed [20:0] FMIN_S = 21'(F_MIN);
  localparam logic signed [20:0] FMAX_S = 21'(F_MAX);

  typedef enum logic [1:0] {IDLE, DIVIDE, APPLY} state_t;

  state_t state, state_nxt;

  logic [HP_W-1:0]  cnt;
  logic             phase;
  logic [4:0]       bit_cnt;
  logic [19:0]      rem;
  logic [DVD_W-1:0] quo;

  logic             start, fin, hp_wrap;
  logic signed [20:0] nxt_raw;
  logic [19:0]      nxt_clamp;
  logic             nxt_lim;
  logic [20:0]      rem_sh;
  logic             ge;
  logic [HP_W-1:0]  quo_sat;

  assign hp_wrap = (cnt == half_period - HP_W'(1));

  // Next frequency in signed 21-bit so a down step below zero cannot wrap.
  always_comb begin
    nxt_raw   = freq_set_up_down ? ($signed({1'b0, freq}) + STEP_S)
                                 : ($signed({1'b0, freq}) - STEP_S);
    nxt_clamp = nxt_raw[19:0];
    nxt_lim   = 1'b0;
    if (nxt_raw < FMIN_S) begin
      nxt_clamp = FMIN_S[19:0];
      nxt_lim   = 1'b1;
    end else if (nxt_raw > FMAX_S) begin
      nxt_clamp = FMAX_S[19:0];
      nxt_lim   = 1'b1;
    end
  end

  // One restoring-division step; freq is stable for the whole DIVIDE phase.
  assign rem_sh  = {rem, DVD[5'(DVD_W - 1) - bit_cnt]};
  assign ge      = (rem_sh >= {1'b0, freq});
  assign quo_sat = (|quo[DVD_W-1:HP_W]) ? {HP_W{1'b1}} : quo[HP_W-1:0];

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    fin       = 1'b0;
    case (state)
      IDLE: if (freq_ready && !freq_opt) begin
        start     = 1'b1;
        state_nxt = DIVIDE;
      end
      DIVIDE: if (bit_cnt == 5'(DVD_W - 1)) state_nxt = APPLY;
      APPLY: if (hp_wrap) begin
        fin       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state       <= IDLE;
      freq        <= 20'(F_INIT);
      half_period <= HP_INIT;
      busy        <= 1'b0;
      at_limit    <= 1'b0;
      data_start  <= 1'b0;
      bit_cnt     <= '0;
      rem         <= '0;
      quo         <= '0;
    end else begin
      state      <= state_nxt;
      data_start <= fin;
      if (start) begin
        freq     <= nxt_clamp;
        at_limit <= nxt_lim;
        busy     <= 1'b1;
        bit_cnt  <= '0;
        rem      <= '0;
        quo      <= '0;
      end
      if (state == DIVIDE) begin
        bit_cnt <= bit_cnt + 5'd1;
        rem     <= ge ? 20'(rem_sh - {1'b0, freq}) : rem_sh[19:0];
        quo     <= {quo[DVD_W-2:0], ge};
      end
      if (fin) begin
        half_period <= quo_sat;
        busy        <= 1'b0;
      end
    end
  end

  // Half-bridge timing: new half_period only lands on a wrap, so halves stay whole.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      cnt   <= '0;
      phase <= 1'b0;
      pwm_h <= 1'b0;
      pwm_l <= 1'b0;
    end else begin
      if (hp_wrap) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + HP_W'(1);
      end
      pwm_h <= phase && (cnt >= DEAD_C);
      pwm_l <= !phase && (cnt >= DEAD_C);
    end
  end

endmodule

// File: tb/tb_freq_stepper.sv
// Directed bench for freq_stepper: main instance at F_INIT plus two instances
// started next to the lower and upper clamps.
module tb_freq_stepper;
  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  // main instance
  logic        rdy_m, dir_m, opt_m;
  logic [19:0] freq_m;
  logic [15:0] hp_m;
  logic        ph_m, pl_m, ds_m, busy_m, lim_m;
  // instance next to F_MIN
  logic        rdy_lo, dir_lo;
  logic [19:0] freq_lo;
  logic [15:0] hp_lo;
  logic        ph_lo, pl_lo, ds_lo, busy_lo, lim_lo;
  // instance at F_MAX
  logic        rdy_hi, dir_hi;
  logic [19:0] freq_hi;
  logic [15:0] hp_hi;
  logic        ph_hi, pl_hi, ds_hi, busy_hi, lim_hi;

  freq_stepper dut (
    .clk(clk), .nrst(nrst), .freq_ready(rdy_m), .freq_set_up_down(dir_m),
    .freq_opt(opt_m), .freq(freq_m), .half_period(hp_m), .pwm_h(ph_m),
    .pwm_l(pl_m), .data_start(ds_m), .busy(busy_m), .at_limit(lim_m));

  freq_stepper #(.F_INIT(20100)) dut_lo (
    .clk(clk), .nrst(nrst), .freq_ready(rdy_lo), .freq_set_up_down(dir_lo),
    .freq_opt(1'b0), .freq(freq_lo), .half_period(hp_lo), .pwm_h(ph_lo),
    .pwm_l(pl_lo), .data_start(ds_lo), .busy(busy_lo), .at_limit(lim_lo));

  freq_stepper #(.F_INIT(100000)) dut_hi (
    .clk(clk), .nrst(nrst), .freq_ready(rdy_hi), .freq_set_up_down(dir_hi),
    .freq_opt(1'b0), .freq(freq_hi), .half_period(hp_hi), .pwm_h(ph_hi),
    .pwm_l(pl_hi), .data_start(ds_hi), .busy(busy_hi), .at_limit(lim_hi));

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One-cycle strobe; returns at the negedge after the sampling posedge.
  task automatic strobe(input int which, input logic d);
    @(negedge clk);
    case (which)
      0: begin rdy_m = 1'b1; dir_m = d; end
      1: begin rdy_lo = 1'b1; dir_lo = d; end
      default: begin rdy_hi = 1'b1; dir_hi = d; end
    endcase
    @(negedge clk);
    rdy_m = 1'b0; rdy_lo = 1'b0; rdy_hi = 1'b0;
  endtask

  task automatic wait_ds(input int which, input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      case (which)
        0: seen = ds_m;
        1: seen = ds_lo;
        default: seen = ds_hi;
      endcase
    end
  endtask

  initial begin
    int  nh, nl, nov, nds, first_h, first_l;
    bit  seen;
    nrst = 1'b0;
    rdy_m = 1'b0; dir_m = 1'b0; opt_m = 1'b0;
    rdy_lo = 1'b0; dir_lo = 1'b0; rdy_hi = 1'b0; dir_hi = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_freq", 32'(freq_m), 40000);
    check("rst_hp", 32'(hp_m), 625);
    check("rst_pwm", {30'd0, ph_m, pl_m}, 0);
    check("rst_flags", {29'd0, ds_m, busy_m, lim_m}, 0);
    check("rst_hp_lo", 32'(hp_lo), 1243);
    check("rst_hp_hi", 32'(hp_hi), 250);

    // free-running PWM: two full periods of 1250
    nrst = 1'b1;
    nh = 0; nl = 0; nov = 0; nds = 0; first_h = 0; first_l = 0;
    for (int i = 1; i <= 2500; i++) begin
      @(negedge clk);
      if (ph_m) begin nh++; if (first_h == 0) first_h = i; end
      if (pl_m) begin nl++; if (first_l == 0) first_l = i; end
      if (ph_m && pl_m) nov++;
      if (ds_m) nds++;
    end
    check("pwm_h_cnt", 32'(nh), 1230);
    check("pwm_l_cnt", 32'(nl), 1230);
    check("pwm_l_first", 32'(first_l), 11);
    check("pwm_h_first", 32'(first_h), 636);
    check("pwm_overlap", 32'(nov), 0);
    check("idle_ds", 32'(nds), 0);

    // single up step
    strobe(0, 1'b1);
    check("up_freq", 32'(freq_m), 40100);
    check("up_busy", 32'(busy_m), 1);
    wait_ds(0, 3000, seen);
    check("up_ds_seen", 32'(seen), 1);
    check("up_hp", 32'(hp_m), 623);
    check("up_busy_clr", 32'(busy_m), 0);
    check("up_lim", 32'(lim_m), 0);
    @(negedge clk);
    check("up_ds_once", 32'(ds_m), 0);

    // strobe while busy is dropped
    strobe(0, 1'b1);
    check("bz_freq1", 32'(freq_m), 40200);
    repeat (9) @(negedge clk);
    strobe(0, 1'b0);
    check("bz_still", 32'(freq_m), 40200);
    wait_ds(0, 3000, seen);
    check("bz_ds_seen", 32'(seen), 1);
    check("bz_hp", 32'(hp_m), 621);
    repeat (30) @(negedge clk);
    check("bz_freq2", 32'(freq_m), 40200);
    check("bz_busy", 32'(busy_m), 0);

    // optimum reached: strobes ignored
    opt_m = 1'b1;
    nds = 0; nh = 0;
    for (int k = 0; k < 5; k++) begin
      strobe(0, 1'b1);
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (ds_m) nds++;
        if (busy_m) nh++;
      end
    end
    check("opt_freq", 32'(freq_m), 40200);
    check("opt_hp", 32'(hp_m), 621);
    check("opt_busy", 32'(nh), 0);
    check("opt_ds", 32'(nds), 0);
    opt_m = 1'b0;
    strobe(0, 1'b0);
    check("opt_off_freq", 32'(freq_m), 40100);
    wait_ds(0, 3000, seen);
    check("opt_off_ds", 32'(seen), 1);
    check("opt_off_hp", 32'(hp_m), 623);

    // reset in the middle of DIVIDE
    strobe(0, 1'b1);
    check("ab_freq", 32'(freq_m), 40200);
    repeat (11) @(negedge clk);
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    check("ab_freq_rst", 32'(freq_m), 40000);
    check("ab_hp_rst", 32'(hp_m), 625);
    check("ab_flags", {28'd0, busy_m, lim_m, ph_m, pl_m}, 0);
    nrst = 1'b1;
    nds = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (ds_m) nds++;
    end
    check("ab_no_ds", 32'(nds), 0);
    check("ab_hp_after", 32'(hp_m), 625);
    check("ab_busy_after", 32'(busy_m), 0);

    // down steps into F_MIN (re-reset restores F_INIT=20100 on dut_lo)
    strobe(1, 1'b0);
    check("lo1_freq", 32'(freq_lo), 20000);
    check("lo1_lim", 32'(lim_lo), 0);
    wait_ds(1, 4000, seen);
    check("lo1_ds", 32'(seen), 1);
    check("lo1_hp", 32'(hp_lo), 1250);
    strobe(1, 1'b0);
    check("lo2_freq", 32'(freq_lo), 20000);
    check("lo2_lim", 32'(lim_lo), 1);
    wait_ds(1, 4000, seen);
    check("lo2_ds", 32'(seen), 1);
    check("lo2_hp", 32'(hp_lo), 1250);

    // up step at F_MAX
    strobe(2, 1'b1);
    check("hi_freq", 32'(freq_hi), 100000);
    check("hi_lim", 32'(lim_hi), 1);
    wait_ds(2, 1000, seen);
    check("hi_ds", 32'(seen), 1);
    check("hi_hp", 32'(hp_hi), 250);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  // gate overlap watch across every instance for the whole run
  always @(negedge clk) begin
    if (nrst && ((ph_m && pl_m) || (ph_lo && pl_lo) || (ph_hi && pl_hi)))
      check("shoot_through", 32'd1, 32'd0);
  end
endmodule
